ring_rr_arbiter: RTL and testbench
==================================

RING_RR_ARBITER -- requirements
Module: ring_rr_arbiter

Interface
REQ-001 Parameter: MAX_BURST, default 4, maximum consecutive grant cycles before forced release (range 1..15; used only when RING_ARB_BURST_EN is defined).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: req  input  4  request lines; bit i is requester i, level-sensitive.
REQ-005 Port: grant  output  4  registered one-hot grant, or 4'b0000 when no requester holds the resource.
REQ-006 Port: grant_id  output  2  binary index of the asserted grant bit; 2'd0 when grant is 0.
REQ-007 Port: busy  output  1  high exactly when grant is nonzero.
REQ-008 Port: ptr  output  4  one-hot ring priority pointer; the highest-priority requester for the next arbitration.

Function
REQ-009 The block SHALL implement a two-state FSM: IDLE (grant 0) and BUSY (one grant bit high).
REQ-010 ptr SHALL always be one-hot; rotate-left means bit i moves to bit i+1, with bit 3 moving to bit 0 (0001->0010->0100->1000->0001).
REQ-011 In IDLE with req nonzero at an edge, the block SHALL grant the first requesting index in the search order p, p+1, p+2, p+3 (mod 4), where p is ptr's set bit; grant is visible after that edge (1-cycle latency), state moves to BUSY, and the burst counter is set to 1.
REQ-012 In IDLE with req == 0, the block SHALL remain in IDLE with grant 0 and ptr unchanged.
REQ-013 In BUSY, while req[grant_id] is sampled high, the grant SHALL hold unchanged; changes on other req bits SHALL have no effect.
REQ-014 In BUSY, when req[grant_id] is sampled low, the block SHALL, at that edge, clear grant, set ptr to rotate-left of the current grant, and return to IDLE.
REQ-015 After any release, at least one cycle with grant 0 SHALL occur before the next grant; grants SHALL never overlap.
REQ-016 The burst counter SHALL be 4 bits, increment once per BUSY cycle in which the grant holds, and saturate at MAX_BURST.
REQ-017 grant_id and busy SHALL be registered, consistent with grant in the same cycle.
REQ-018 A requester dropping req in the same cycle it would be granted SHALL NOT be granted; arbitration uses only req sampled at the edge.

Reset
REQ-019 When reset is sampled high, the block SHALL set grant=4'b0000, grant_id=2'd0, busy=0, ptr=4'b0001, burst counter=0, and state=IDLE, regardless of state or req.
REQ-020 Reset SHALL take priority over every other transition, including a release or forced release in the same cycle.
REQ-021 After reset is sampled low, the first arbitration SHALL occur at the next edge with req nonzero.

Configuration
REQ-022 Macro RING_ARB_BURST_EN defined: in BUSY, when the burst counter equals MAX_BURST and any other req bit is sampled high, the block SHALL force release as in REQ-014, even though req[grant_id] is still high.
REQ-023 Macro RING_ARB_BURST_EN defined, with no competing request: the grant SHALL continue indefinitely with the counter saturated, and forced release SHALL occur at the first edge at which a competitor is sampled high.
REQ-024 Macro RING_ARB_BURST_EN undefined: no forced release SHALL occur, the burst counter MAY be omitted, and MAX_BURST SHALL be ignored.

Verification
REQ-025 Reset: hold reset high for 2 cycles with req=1111 -> grant=0000, busy=0, ptr=0001; the first grant after deassertion is 0001.
REQ-026 Rotation: starting with ptr=0001, apply req=1010 -> grant=0010, grant_id=1. Drop req[1] -> the next edge gives grant=0000 and ptr=0100. The following edge gives grant=1000, grant_id=3.
REQ-027 Fairness with macro defined, MAX_BURST=4: hold req=1111 constant -> the sequence repeats as 0001 x4, 0000 x1, 0010 x4, 0000 x1, 0100 x4, 0000 x1, 1000 x4, 0000 x1.
REQ-028 No macro: hold req=1111 constant -> grant=0001 is held for 50 cycles and ptr stays 0001.
REQ-029 Macro defined, no competitor: req=0001 for 10 cycles -> grant=0001 throughout. Then raise req[2] -> the next edge gives grant=0000 and ptr=0010. The following edge gives grant=0100.
REQ-030 Reset mid-operation: assert reset while grant=0100 and ptr=0100 -> the next edge gives grant=0000 and ptr=0001. After deassertion with req=0101, the first grant is 0001.

Source files
------------

// File: rtl/ring_rr_arbiter.sv
// Four-requester round-robin arbiter with a one-hot ring pointer and registered grant outputs.
// Define RING_ARB_BURST_EN to force release after MAX_BURST held cycles when another requester waits.
module ring_rr_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] grant_id,
  output logic       busy,
  output logic [3:0] ptr
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

  logic [0:0] state_q, state_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] grant_id_q, grant_id_d;
  logic       busy_q, busy_d;
  logic [3:0] ptr_q, ptr_d;
  logic [3:0] burst_q, burst_d;

  logic [1:0] ptrIdx;
  logic [1:0] searchIdx;
  logic [1:0] pickIdx;
  logic       pickFound;
  logic       forceRelease;
  logic       release_now;

  function automatic logic [1:0] oneHotToIdx(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    case (v)
      4'b0010: r = 2'd1;
      4'b0100: r = 2'd2;
      4'b1000: r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  assign ptrIdx = oneHotToIdx(ptr_q);

  // Walk the ring starting at the pointer; the first requester found wins.
  always_comb begin
    pickFound = 1'b0;
    pickIdx   = ptrIdx;
    searchIdx = 2'd0;
    for (int k = 0; k < 4; k++) begin
      searchIdx = ptrIdx + 2'(k);
      if (!pickFound && req[searchIdx]) begin
        pickFound = 1'b1;
        pickIdx   = searchIdx;
      end
    end
  end

`ifdef RING_ARB_BURST_EN
  logic competitor;
  assign competitor   = |(req & ~grant_q);
  assign forceRelease = (burst_q == BURST_MAX) && competitor;
`else
  assign forceRelease = 1'b0;
`endif

  assign release_now = !req[grant_id_q] || forceRelease;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    busy_d     = busy_q;
    ptr_d      = ptr_q;
    burst_d    = burst_q;
    case (state_q)
      IDLE: begin
        if (pickFound) begin
          state_d    = BUSY;
          grant_d    = 4'b0001 << pickIdx;
          grant_id_d = pickIdx;
          busy_d     = 1'b1;
          burst_d    = 4'd1;
        end
      end
      BUSY: begin
        // Releasing hands priority to the neighbour just past the owner.
        if (release_now) begin
          state_d    = IDLE;
          grant_d    = 4'b0000;
          grant_id_d = 2'd0;
          busy_d     = 1'b0;
          ptr_d      = {grant_q[2:0], grant_q[3]};
          burst_d    = 4'd0;
        end else if (burst_q < BURST_MAX) begin
          burst_d = burst_q + 4'd1;
        end
      end
      default: begin
        state_d    = IDLE;
        grant_d    = 4'b0000;
        grant_id_d = 2'd0;
        busy_d     = 1'b0;
        ptr_d      = 4'b0001;
        burst_d    = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= 4'b0000;
      grant_id_q <= 2'd0;
      busy_q     <= 1'b0;
      ptr_q      <= 4'b0001;
      burst_q    <= 4'd0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      busy_q     <= busy_d;
      ptr_q      <= ptr_d;
      burst_q    <= burst_d;
    end
  end

  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;
  assign ptr      = ptr_q;

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Directed bench for ring_rr_arbiter; selects the burst-release sequence when RING_ARB_BURST_EN is defined.
module tb_ring_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grantId;
  logic       busy;
  logic [3:0] ptr;

  int checkCount = 0;
  int passCount  = 0;

  ring_rr_arbiter #(.MAX_BURST(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .grant    (grant),
    .grant_id (grantId),
    .busy     (busy),
    .ptr      (ptr)
  );

  always #5 clk = ~clk;

  // Drive inputs at the falling edge, then settle just after the next rising edge.
  task automatic applyStimulus(input logic rst, input logic [3:0] r);
    @(negedge clk);
    reset = rst;
    req   = r;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] expGrant,
                             input logic [1:0] expId, input logic expBusy,
                             input logic [3:0] expPtr);
    checkCount++;
    assert ({grant, grantId, busy, ptr} === {expGrant, expId, expBusy, expPtr})
      passCount++;
    else
      $error("[TB] FAIL %s: got grant=%b id=%0d busy=%b ptr=%b, expected grant=%b id=%0d busy=%b ptr=%b",
             tag, grant, grantId, busy, ptr, expGrant, expId, expBusy, expPtr);
  endtask

  initial begin
    logic [3:0] expG;
    logic [3:0] expP;
    reset = 1'b1;
    req   = 4'b1111;

    // Reset held two cycles with every requester active.
    applyStimulus(1'b1, 4'b1111);
    checkOutput("reset_c1", 4'b0000, 2'd0, 1'b0, 4'b0001);
    applyStimulus(1'b1, 4'b1111);
    checkOutput("reset_c2", 4'b0000, 2'd0, 1'b0, 4'b0001);
    applyStimulus(1'b0, 4'b1111);
    checkOutput("first_grant", 4'b0001, 2'd0, 1'b1, 4'b0001);

    // Rotation from a fresh pointer.
    applyStimulus(1'b1, 4'b0000);
    checkOutput("reset_again", 4'b0000, 2'd0, 1'b0, 4'b0001);
    applyStimulus(1'b0, 4'b1010);
    checkOutput("rot_grant1", 4'b0010, 2'd1, 1'b1, 4'b0001);
    applyStimulus(1'b0, 4'b1000);
    checkOutput("rot_release", 4'b0000, 2'd0, 1'b0, 4'b0100);
    applyStimulus(1'b0, 4'b1000);
    checkOutput("rot_grant3", 4'b1000, 2'd3, 1'b1, 4'b0100);
    applyStimulus(1'b0, 4'b1001);
    checkOutput("hold_other_req", 4'b1000, 2'd3, 1'b1, 4'b0100);
    applyStimulus(1'b0, 4'b0001);
    checkOutput("release_wrap", 4'b0000, 2'd0, 1'b0, 4'b0001);
    applyStimulus(1'b0, 4'b0000);
    checkOutput("idle_no_req", 4'b0000, 2'd0, 1'b0, 4'b0001);
    applyStimulus(1'b0, 4'b0010);
    checkOutput("skip_to_1", 4'b0010, 2'd1, 1'b1, 4'b0001);
    applyStimulus(1'b0, 4'b0000);
    checkOutput("release_1", 4'b0000, 2'd0, 1'b0, 4'b0100);
    applyStimulus(1'b0, 4'b0011);
    checkOutput("search_wraps", 4'b0001, 2'd0, 1'b1, 4'b0100);
    applyStimulus(1'b0, 4'b0000);
    checkOutput("release_0", 4'b0000, 2'd0, 1'b0, 4'b0010);

`ifdef RING_ARB_BURST_EN
    // Constant full request: each owner keeps four cycles, then one idle gap.
    applyStimulus(1'b1, 4'b0000);
    for (int seg = 0; seg < 4; seg++) begin
      for (int k = 0; k < 4; k++) begin
        applyStimulus(1'b0, 4'b1111);
        expG = 4'b0001 << seg;
        checkOutput($sformatf("fair_s%0d_k%0d", seg, k), expG, 2'(seg), 1'b1, expG);
      end
      applyStimulus(1'b0, 4'b1111);
      expP = 4'b0001 << ((seg + 1) % 4);
      checkOutput($sformatf("fair_gap%0d", seg), 4'b0000, 2'd0, 1'b0, expP);
    end

    // Lone requester saturates the counter, then yields to a late competitor.
    applyStimulus(1'b1, 4'b0000);
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b0, 4'b0001);
      checkOutput($sformatf("solo_c%0d", c), 4'b0001, 2'd0, 1'b1, 4'b0001);
    end
    applyStimulus(1'b0, 4'b0101);
    checkOutput("forced_release", 4'b0000, 2'd0, 1'b0, 4'b0010);
    applyStimulus(1'b0, 4'b0101);
    checkOutput("competitor_grant", 4'b0100, 2'd2, 1'b1, 4'b0010);
`else
    // Without forced release the first owner keeps the resource.
    applyStimulus(1'b1, 4'b0000);
    for (int c = 0; c < 50; c++) begin
      applyStimulus(1'b0, 4'b1111);
      checkOutput($sformatf("hold_c%0d", c), 4'b0001, 2'd0, 1'b1, 4'b0001);
    end
`endif

    // Reset mid-grant wins over a simultaneous release.
    applyStimulus(1'b1, 4'b0000);
    applyStimulus(1'b0, 4'b0010);
    checkOutput("mid_setup_g1", 4'b0010, 2'd1, 1'b1, 4'b0001);
    applyStimulus(1'b0, 4'b0000);
    checkOutput("mid_setup_rel", 4'b0000, 2'd0, 1'b0, 4'b0100);
    applyStimulus(1'b0, 4'b0100);
    checkOutput("mid_setup_g2", 4'b0100, 2'd2, 1'b1, 4'b0100);
    applyStimulus(1'b1, 4'b0000);
    checkOutput("mid_reset", 4'b0000, 2'd0, 1'b0, 4'b0001);
    applyStimulus(1'b0, 4'b0101);
    checkOutput("post_reset_grant", 4'b0001, 2'd0, 1'b1, 4'b0001);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
